ex_stage: RTL and testbench

- Execute stage of the 5-stage RV32 pipeline; consumes the ID/EX register outputs and produces the EX/MEM register contents.
- Contains:
  - forwarding operand muxes;
  - 8-op ALU;
  - branch/jump resolution and redirect target for fetch;
  - the EX/MEM pipeline register, with stall (enable) and flush.
- Redirect outputs are combinational to fetch and hazard logic. All data outputs to MEM are registered.

---
 rtl/ex_stage.sv | 126 ++++++++++++
 tb/tb_ex_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32 execute stage: operand forwarding, ALU, branch/jump resolve, EX/MEM register
module ex_stage #(
  parameter int unsigned XLEN     = 32,
  parameter logic [6:0]  OPC_JALR = 7'b1100111
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clk_en,
  input  logic            i_ex_mem_flush,
  input  logic [4:0]      i_rd_e,
  input  logic [XLEN-1:0] i_pc_e,
  input  logic [XLEN-1:0] i_pc_p4_e,
  input  logic [XLEN-1:0] i_imm32_e,
  input  logic [XLEN-1:0] i_regs_do1_e,
  input  logic [XLEN-1:0] i_regs_do2_e,
  input  logic            i_reg_wr_e,
  input  logic            i_mem_write_e,
  input  logic            i_jmp_e,
  input  logic            i_branch_e,
  input  logic            i_alu_src_e,
  input  logic [1:0]      i_result_src_e,
  input  logic [2:0]      i_alu_ctl_e,
  input  logic [6:0]      i_opcode_e,
  input  logic [1:0]      i_fwd_a_e,
  input  logic [1:0]      i_fwd_b_e,
  input  logic [XLEN-1:0] i_result_w,
  output logic            o_pc_src_e,
  output logic [XLEN-1:0] o_pc_target_e,
  output logic [XLEN-1:0] o_alu_result_m,
  output logic [XLEN-1:0] o_write_data_m,
  output logic [XLEN-1:0] o_pc_p4_m,
  output logic [XLEN-1:0] o_pc_m,
  output logic [4:0]      o_rd_m,
  output logic            o_reg_wr_m,
  output logic            o_mem_write_m,
  output logic [1:0]      o_result_src_m,
  output logic [6:0]      o_opcode_m
);

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc_p4;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            reg_wr;
    logic            mem_write;
    logic [1:0]      result_src;
    logic [6:0]      opcode;
  } exmem_t;

  exmem_t exmem_d, exmem_q;

  logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, alu_result, jalr_sum;
  logic            zero;

  // Select 10 feeds back the registered ALU result, so a stalled stage sees the held value.
  always_comb begin
    case (i_fwd_a_e)
      2'b01:   fwd_a = i_result_w;
      2'b10:   fwd_a = exmem_q.alu_result;
      default: fwd_a = i_regs_do1_e;
    endcase
    case (i_fwd_b_e)
      2'b01:   fwd_b = i_result_w;
      2'b10:   fwd_b = exmem_q.alu_result;
      default: fwd_b = i_regs_do2_e;
    endcase
  end

  assign src_a = fwd_a;
  assign src_b = i_alu_src_e ? i_imm32_e : fwd_b;

  always_comb begin
    case (i_alu_ctl_e)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b100:  alu_result = src_a ^ src_b;
      3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      3'b110:  alu_result = src_a << src_b[4:0];
      default: alu_result = src_a >> src_b[4:0];
    endcase
  end

  assign zero     = (alu_result == '0);
  assign jalr_sum = src_a + i_imm32_e;

  assign o_pc_src_e    = i_jmp_e | (i_branch_e & zero);
  assign o_pc_target_e = (i_opcode_e == OPC_JALR) ? {jalr_sum[XLEN-1:1], 1'b0}
                                                  : (i_pc_e + i_imm32_e);

  always_comb begin
    exmem_d = exmem_q;
    if (i_ex_mem_flush) begin
      exmem_d = '0;
    end else if (i_clk_en) begin
      exmem_d.alu_result = alu_result;
      exmem_d.write_data = fwd_b;
      exmem_d.pc_p4      = i_pc_p4_e;
      exmem_d.pc         = i_pc_e;
      exmem_d.rd         = i_rd_e;
      exmem_d.reg_wr     = i_reg_wr_e;
      exmem_d.mem_write  = i_mem_write_e;
      exmem_d.result_src = i_result_src_e;
      exmem_d.opcode     = i_opcode_e;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) exmem_q <= '0;
    else       exmem_q <= exmem_d;
  end

  assign o_alu_result_m = exmem_q.alu_result;
  assign o_write_data_m = exmem_q.write_data;
  assign o_pc_p4_m      = exmem_q.pc_p4;
  assign o_pc_m         = exmem_q.pc;
  assign o_rd_m         = exmem_q.rd;
  assign o_reg_wr_m     = exmem_q.reg_wr;
  assign o_mem_write_m  = exmem_q.mem_write;
  assign o_result_src_m = exmem_q.result_src;
  assign o_opcode_m     = exmem_q.opcode;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized self-checking bench for ex_stage against a behavioural model
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst, clk_en, flush;
  logic [4:0]  rd;
  logic [31:0] pc, pc_p4, imm, do1, do2, result_w;
  logic        reg_wr, mem_write, jmp, branch, alu_src;
  logic [1:0]  result_src, fwd_a, fwd_b;
  logic [2:0]  alu_ctl;
  logic [6:0]  opcode;

  logic        pc_src;
  logic [31:0] pc_target, alu_result_m, write_data_m, pc_p4_m, pc_m;
  logic [4:0]  rd_m;
  logic        reg_wr_m, mem_write_m;
  logic [1:0]  result_src_m;
  logic [6:0]  opcode_m;

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the EX/MEM register contents the bench expects.
  logic [31:0] m_alu, m_wd, m_pc4, m_pc;
  logic [4:0]  m_rd;
  logic        m_rw, m_mw;
  logic [1:0]  m_rs;
  logic [6:0]  m_op;

  always #5 clk = ~clk;

  ex_stage dut (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_ex_mem_flush(flush),
    .i_rd_e(rd), .i_pc_e(pc), .i_pc_p4_e(pc_p4), .i_imm32_e(imm),
    .i_regs_do1_e(do1), .i_regs_do2_e(do2),
    .i_reg_wr_e(reg_wr), .i_mem_write_e(mem_write), .i_jmp_e(jmp),
    .i_branch_e(branch), .i_alu_src_e(alu_src), .i_result_src_e(result_src),
    .i_alu_ctl_e(alu_ctl), .i_opcode_e(opcode), .i_fwd_a_e(fwd_a), .i_fwd_b_e(fwd_b),
    .i_result_w(result_w),
    .o_pc_src_e(pc_src), .o_pc_target_e(pc_target),
    .o_alu_result_m(alu_result_m), .o_write_data_m(write_data_m),
    .o_pc_p4_m(pc_p4_m), .o_pc_m(pc_m), .o_rd_m(rd_m), .o_reg_wr_m(reg_wr_m),
    .o_mem_write_m(mem_write_m), .o_result_src_m(result_src_m), .o_opcode_m(opcode_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                       input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'd1) return wb;
    if (sel == 2'd2) return mem;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return a << (b % 32);
      default: return a >> (b % 32);
    endcase
  endfunction

  task automatic set_idle();
    rst = 0; clk_en = 1; flush = 0; rd = 0; pc = 0; pc_p4 = 0; imm = 0;
    do1 = 0; do2 = 0; result_w = 0; reg_wr = 0; mem_write = 0; jmp = 0;
    branch = 0; alu_src = 0; result_src = 0; fwd_a = 0; fwd_b = 0; alu_ctl = 0; opcode = 0;
  endtask

  // Check combinational redirect now, then advance one edge and check the register image.
  task automatic cycle();
    logic [31:0] a, b, sb, res, tgt;
    #1;
    a   = pick(fwd_a, do1, result_w, m_alu);
    b   = pick(fwd_b, do2, result_w, m_alu);
    sb  = alu_src ? imm : b;
    res = ref_alu(alu_ctl, a, sb);
    tgt = (opcode == 7'b1100111) ? ((a + imm) & ~32'd1) : (pc + imm);
    check("pc_src", 32'(pc_src), 32'(jmp | (branch & (res == 0))));
    check("pc_target", pc_target, tgt);
    @(posedge clk);
    if (rst || flush) begin
      m_alu = 0; m_wd = 0; m_pc4 = 0; m_pc = 0; m_rd = 0; m_rw = 0; m_mw = 0; m_rs = 0; m_op = 0;
    end else if (clk_en) begin
      m_alu = res; m_wd = b; m_pc4 = pc_p4; m_pc = pc; m_rd = rd;
      m_rw = reg_wr; m_mw = mem_write; m_rs = result_src; m_op = opcode;
    end
    #1;
    check("alu_result_m", alu_result_m, m_alu);
    check("write_data_m", write_data_m, m_wd);
    check("pc_p4_m", pc_p4_m, m_pc4);
    check("pc_m", pc_m, m_pc);
    check("rd_m", 32'(rd_m), 32'(m_rd));
    check("reg_wr_m", 32'(reg_wr_m), 32'(m_rw));
    check("mem_write_m", 32'(mem_write_m), 32'(m_mw));
    check("result_src_m", 32'(result_src_m), 32'(m_rs));
    check("opcode_m", 32'(opcode_m), 32'(m_op));
    @(negedge clk);
  endtask

  task automatic randomize_inputs();
    rd = 5'($urandom); pc = $urandom & ~32'd3; pc_p4 = pc + 4; imm = $urandom;
    if ($urandom_range(0, 3) == 0) imm = 32'($urandom_range(0, 40));
    do1 = $urandom; do2 = $urandom; result_w = $urandom;
    if ($urandom_range(0, 3) == 0) do2 = do1;
    reg_wr = 1'($urandom); mem_write = 1'($urandom); jmp = ($urandom_range(0, 5) == 0);
    branch = 1'($urandom); alu_src = 1'($urandom); result_src = 2'($urandom);
    alu_ctl = 3'($urandom); fwd_a = 2'($urandom); fwd_b = 2'($urandom);
    opcode = ($urandom_range(0, 3) == 0) ? 7'b1100111 : 7'($urandom);
  endtask

  initial begin
    m_alu = 0; m_wd = 0; m_pc4 = 0; m_pc = 0; m_rd = 0; m_rw = 0; m_mw = 0; m_rs = 0; m_op = 0;
    set_idle();
    rst = 1;
    @(negedge clk);
    cycle();
    cycle();
    rst = 0;

    // ADD x3 = 5 + 7
    do1 = 5; do2 = 7; rd = 3; reg_wr = 1; alu_ctl = 3'd0;
    cycle();
    check("add_result", alu_result_m, 32'd12);
    check("add_wdata", write_data_m, 32'd7);

    // SUB with A forwarded from the registered result
    fwd_a = 2'd2; do1 = 32'hDEAD; do2 = 2; alu_ctl = 3'd1;
    cycle();
    check("fwd_a_sub", alu_result_m, 32'd10);

    // SLT 0 < -1 signed is false
    fwd_a = 0; do1 = 0; fwd_b = 2'd1; result_w = 32'hFFFF_FFFF; alu_ctl = 3'd5;
    cycle();
    check("fwd_b_slt", alu_result_m, 32'd0);

    // BEQ taken / not taken
    set_idle();
    branch = 1; alu_ctl = 3'd1; do1 = 32'h40; do2 = 32'h40; pc = 32'h100; imm = 32'h20;
    #1;
    check("beq_taken", 32'(pc_src), 32'd1);
    check("beq_target", pc_target, 32'h120);
    do2 = 32'h41;
    #1;
    check("beq_not_taken", 32'(pc_src), 32'd0);
    cycle();

    // JALR clears bit 0
    set_idle();
    jmp = 1; opcode = 7'b1100111; do1 = 32'h203; imm = 4; pc_p4 = 32'h504; reg_wr = 1;
    #1;
    check("jalr_target", pc_target, 32'h206);
    cycle();
    check("jalr_pc_p4", pc_p4_m, 32'h504);

    // Shifts
    set_idle();
    alu_ctl = 3'd6; do1 = 3; alu_src = 1; imm = 32'h21;
    cycle();
    check("sll_amt", alu_result_m, 32'd6);
    alu_ctl = 3'd7; do1 = 32'h8000_0000; imm = 31;
    cycle();
    check("srl_31", alu_result_m, 32'd1);

    // Stall for three cycles while inputs churn, then flush
    set_idle();
    do1 = 32'h1234; do2 = 32'h1; rd = 9; reg_wr = 1; mem_write = 1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      clk_en = 0;
      cycle();
      check("stall_hold", alu_result_m, 32'h1235);
    end
    randomize_inputs();
    clk_en = 1; flush = 1;
    cycle();
    check("flush_reg_wr", 32'(reg_wr_m), 32'd0);
    flush = 0;

    // Reset mid-stream with enable high, held two cycles
    randomize_inputs();
    cycle();
    randomize_inputs();
    rst = 1; clk_en = 1;
    cycle();
    randomize_inputs();
    rst = 1; clk_en = 1;
    cycle();
    check("rst_alu", alu_result_m, 32'd0);
    rst = 0;

    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      clk_en = ($urandom_range(0, 3) != 0);
      flush  = ($urandom_range(0, 9) == 0);
      rst    = ($urandom_range(0, 29) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
